spi_master_tx: RTL and testbench
================================

Name: spi_master_tx

Overview:
- SPI master stage directly downstream of the 32-bit command FIFO.
- Pops one word per frame through the FIFO read handshake and shifts it out MSB-first on MOSI, SPI mode 0 (CPOL=0, CPHA=0).
- Captures MISO into a 32-bit receive word, presented with a one-cycle valid pulse for an RX FIFO write port.
- Frames are separated by chip-select deassertion.

Parameters:
- CLK_DIV, 4, system clocks per SCLK half-period; legal range 1..255.
- WORD_W, 32, bits per frame; must equal the FIFO data width.

Ports:
- clk  in  1  system clock; all logic on rising edge
- rst  in  1  asynchronous, active-low reset
- enable  in  1  allows a new frame to start; sampled only in IDLE
- fifo_empty  in  1  upstream FIFO empty flag
- fifo_rd_en  out  1  one-cycle read strobe to the FIFO
- fifo_data  in  32  FIFO read data
- fifo_valid  in  1  FIFO read-data valid; one cycle after a granted read
- rx_data  out  32  last received word
- rx_valid  out  1  one-cycle pulse when rx_data updates
- busy  out  1  high in every state except IDLE
- sclk  out  1  SPI clock; idles low
- mosi  out  1  SPI data out
- miso  in  1  SPI data in
- cs_n  out  1  chip select, active low

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE; cs_n=1, sclk=0, mosi=0.
  - fifo_rd_en=0, rx_valid=0, rx_data=0, busy=0.
  - All counters and shift registers cleared.
  - Reset mid-frame aborts immediately; no partial rx_valid is issued.
- States: IDLE, FETCH, SETUP, SHIFT, HOLD, GAP.
- IDLE: if enable=1 and fifo_empty=0, drive fifo_rd_en=1 for exactly one cycle and go to FETCH.
- FETCH:
  - If fifo_valid=1: load fifo_data into tx_shift, drive mosi=fifo_data[31], drive cs_n=0, go to SETUP.
  - If fifo_valid=0: return to IDLE without asserting cs_n (protocol fault; no retry).
- SETUP: hold cs_n=0, sclk=0 for CLK_DIV cycles, then enter SHIFT.
- SHIFT:
  - A divider counter runs 0..CLK_DIV-1; at terminal count sclk toggles and the counter wraps.
  - Rising toggle: sample miso into rx_shift LSB, shifting left.
  - Falling toggle, bit_cnt<WORD_W-1: increment bit_cnt and shift tx_shift left; mosi = new tx_shift MSB.
  - Falling toggle, bit_cnt=WORD_W-1: go to HOLD with sclk=0.
  - A frame is exactly 2*WORD_W*CLK_DIV cycles of SHIFT and 32 rising edges of sclk.
- HOLD:
  - cs_n stays 0 for CLK_DIV cycles.
  - On exit: cs_n=1, rx_data=rx_shift, rx_valid=1 for one cycle, go to GAP.
- GAP:
  - cs_n=1 and mosi=0 for CLK_DIV cycles, then IDLE.
  - This gives a minimum CS-high time of CLK_DIV+1 cycles before the next fetch.
- Enable dropping mid-frame does not abort; the current frame completes.
- fifo_empty is ignored outside IDLE. The FIFO may fill or empty freely during a frame.
- Back-to-back words with enable=1 and FIFO non-empty: the next fifo_rd_en is issued on the first IDLE cycle after GAP.
- CLK_DIV=1: sclk toggles every cycle, giving an SCLK of clk/2.
- All outputs are registered; sclk, mosi and cs_n are glitch-free.

Test Plan:
- Reset with CLK_DIV=2, hold rst=0, toggle clk:
  - cs_n=1, sclk=0, mosi=0, busy=0, rx_valid=0.
- Single frame: preload FIFO with 0xA5A5_0F0F, tie miso to a slave model returning 0x1234_5678, enable=1:
  - One fifo_rd_en pulse.
  - 32 sclk rising edges; bits on mosi MSB-first equal 0xA5A50F0F.
  - rx_valid pulses once with rx_data=0x12345678.
  - cs_n is low for 2+128+2 cycles.
- Back-to-back: FIFO holds 0x00000001 and 0xFFFFFFFF, enable=1:
  - Two frames, each preceded by its own fifo_rd_en.
  - cs_n is high for at least 3 cycles between frames; second frame's mosi is all ones.
- Empty FIFO with enable=1 for 50 cycles:
  - fifo_rd_en never asserts; busy=0; cs_n=1.
- enable dropped mid-SHIFT (after 10 bits):
  - Frame completes all 32 bits with one rx_valid; no further fetch occurs while enable=0.
- Reset asserted at bit 16:
  - Outputs go to reset values asynchronously; no rx_valid.
  - After release with FIFO non-empty, the next frame starts cleanly from bit 31.

Source files
------------

// File: rtl/spi_master_tx.sv
// SPI mode-0 transmit master: pops one FIFO word per frame, shifts it out MSB-first
// and returns the word captured on MISO with a one-cycle valid pulse.
module spi_master_tx #(
    parameter int unsigned CLK_DIV = 4,
    parameter int unsigned WORD_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic              fifo_empty,
    output logic              fifo_rd_en,
    input  logic [WORD_W-1:0] fifo_data,
    input  logic              fifo_valid,
    output logic [WORD_W-1:0] rx_data,
    output logic              rx_valid,
    output logic              busy,
    output logic              sclk,
    output logic              mosi,
    input  logic              miso,
    output logic              cs_n
);

    localparam int unsigned BW = $clog2(WORD_W);
    localparam logic [7:0]    DIV_LAST = 8'(CLK_DIV - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(WORD_W - 1);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        SETUP,
        SHIFT,
        HOLD,
        GAP
    } state_t;

    state_t            state_q, state_d;
    logic [7:0]        div_q, div_d;
    logic [BW-1:0]     bit_q, bit_d;
    logic [WORD_W-2:0] tx_q, tx_d;
    logic [WORD_W-1:0] rx_shift_q, rx_shift_d;
    logic [WORD_W-1:0] rx_data_q, rx_data_d;
    logic              rx_valid_q, rx_valid_d;
    logic              rd_en_q, rd_en_d;
    logic              cs_n_q, cs_n_d;
    logic              sclk_q, sclk_d;
    logic              mosi_q, mosi_d;
    logic              busy_q, busy_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            div_q      <= '0;
            bit_q      <= '0;
            tx_q       <= '0;
            rx_shift_q <= '0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            rd_en_q    <= 1'b0;
            cs_n_q     <= 1'b1;
            sclk_q     <= 1'b0;
            mosi_q     <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            div_q      <= div_d;
            bit_q      <= bit_d;
            tx_q       <= tx_d;
            rx_shift_q <= rx_shift_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            rd_en_q    <= rd_en_d;
            cs_n_q     <= cs_n_d;
            sclk_q     <= sclk_d;
            mosi_q     <= mosi_d;
            busy_q     <= busy_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        div_d      = div_q;
        bit_d      = bit_q;
        tx_d       = tx_q;
        rx_shift_d = rx_shift_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = 1'b0;
        rd_en_d    = 1'b0;
        cs_n_d     = cs_n_q;
        sclk_d     = sclk_q;
        mosi_d     = mosi_q;

        case (state_q)
            IDLE: begin
                if (enable && !fifo_empty) begin
                    rd_en_d = 1'b1;
                    state_d = FETCH;
                end
            end
            FETCH: begin
                // The registered read strobe is visible to the FIFO during the first
                // FETCH cycle, so its read data is checked on the following cycle.
                if (!rd_en_q) begin
                    if (fifo_valid) begin
                        tx_d       = fifo_data[WORD_W-2:0];
                        mosi_d     = fifo_data[WORD_W-1];
                        cs_n_d     = 1'b0;
                        div_d      = '0;
                        bit_d      = '0;
                        rx_shift_d = '0;
                        state_d    = SETUP;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            SETUP: begin
                if (div_q == DIV_LAST) begin
                    div_d   = '0;
                    state_d = SHIFT;
                end else begin
                    div_d = div_q + 8'd1;
                end
            end
            SHIFT: begin
                if (div_q == DIV_LAST) begin
                    div_d = '0;
                    if (!sclk_q) begin
                        sclk_d     = 1'b1;
                        rx_shift_d = {rx_shift_q[WORD_W-2:0], miso};
                    end else begin
                        sclk_d = 1'b0;
                        if (bit_q == BIT_LAST) begin
                            state_d = HOLD;
                        end else begin
                            // tx_q holds the bits still to send; the current one lives in mosi_q.
                            bit_d  = bit_q + 1'b1;
                            mosi_d = tx_q[WORD_W-2];
                            tx_d   = {tx_q[WORD_W-3:0], 1'b0};
                        end
                    end
                end else begin
                    div_d = div_q + 8'd1;
                end
            end
            HOLD: begin
                if (div_q == DIV_LAST) begin
                    div_d      = '0;
                    cs_n_d     = 1'b1;
                    mosi_d     = 1'b0;
                    rx_data_d  = rx_shift_q;
                    rx_valid_d = 1'b1;
                    state_d    = GAP;
                end else begin
                    div_d = div_q + 8'd1;
                end
            end
            GAP: begin
                if (div_q == DIV_LAST) begin
                    div_d   = '0;
                    state_d = IDLE;
                end else begin
                    div_d = div_q + 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    assign fifo_rd_en = rd_en_q;
    assign rx_data    = rx_data_q;
    assign rx_valid   = rx_valid_q;
    assign busy       = busy_q;
    assign sclk       = sclk_q;
    assign mosi       = mosi_q;
    assign cs_n       = cs_n_q;

endmodule

// File: tb/tb_spi_master_tx.sv
// Directed bench for spi_master_tx with a FIFO model and a mode-0 SPI slave model.
module tb_spi_master_tx;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        enable = 1'b0;
    logic        fifo_empty;
    logic        fifo_rd_en;
    logic [31:0] fifo_data = '0;
    logic        fifo_valid = 1'b0;
    logic [31:0] rx_data;
    logic        rx_valid;
    logic        busy;
    logic        sclk;
    logic        mosi;
    logic        miso;
    logic        cs_n;

    int n_vec = 0;
    int n_err = 0;

    spi_master_tx #(.CLK_DIV(2), .WORD_W(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .fifo_empty (fifo_empty),
        .fifo_rd_en (fifo_rd_en),
        .fifo_data  (fifo_data),
        .fifo_valid (fifo_valid),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .busy       (busy),
        .sclk       (sclk),
        .mosi       (mosi),
        .miso       (miso),
        .cs_n       (cs_n)
    );

    always #5 clk = ~clk;

    // FIFO model: registered read data, valid one cycle after a granted read.
    logic [31:0] fq[$];
    int          fcount = 0;
    assign fifo_empty = (fcount == 0);

    always @(posedge clk) begin
        if (fifo_rd_en && fcount != 0) begin
            fifo_data  <= fq.pop_front();
            fcount      = fcount - 1;
            fifo_valid <= 1'b1;
        end else begin
            fifo_valid <= 1'b0;
        end
    end

    // Mode-0 slave: reloads on CS fall, shifts out on SCLK fall; records MOSI on SCLK rise.
    logic [31:0] slv_word = '0;
    logic [31:0] slv = '0;
    logic [31:0] mosi_cap = '0;
    logic [31:0] mosi_log[$];
    int          rise_cnt = 0;
    assign miso = slv[31];

    always @(negedge cs_n) begin
        slv      = slv_word;
        mosi_cap = '0;
        rise_cnt = 0;
    end
    always @(posedge cs_n) mosi_log.push_back(mosi_cap);
    always @(negedge sclk) slv = {slv[30:0], 1'b0};
    always @(posedge sclk) begin
        rise_cnt = rise_cnt + 1;
        mosi_cap = {mosi_cap[30:0], mosi};
    end

    int          rd_cnt = 0;
    int          rx_cnt = 0;
    int          busy_cnt = 0;
    int          low_run = 0;
    int          low_len = 0;
    int          high_run = 0;
    int          gap_len = 0;
    logic [31:0] rx_last = '0;
    logic [31:0] rx_log[$];

    always @(negedge clk) begin
        if (fifo_rd_en) rd_cnt = rd_cnt + 1;
        if (busy) busy_cnt = busy_cnt + 1;
        if (rx_valid) begin
            rx_cnt  = rx_cnt + 1;
            rx_last = rx_data;
            rx_log.push_back(rx_data);
        end
        if (!cs_n) begin
            low_run = low_run + 1;
            if (high_run != 0) gap_len = high_run;
            high_run = 0;
        end else begin
            high_run = high_run + 1;
            if (low_run != 0) low_len = low_run;
            low_run = 0;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic push(input logic [31:0] w);
        fq.push_back(w);
        fcount = fcount + 1;
    endtask

    task automatic wait_rx(input int target, input int maxc);
        int i = 0;
        while (rx_cnt < target && i < maxc) begin
            tick(1);
            i++;
        end
    endtask

    task automatic wait_rise(input int target, input int maxc);
        int i = 0;
        while (rise_cnt < target && i < maxc) begin
            tick(1);
            i++;
        end
    endtask

    task automatic clear_counts();
        rd_cnt   = 0;
        rx_cnt   = 0;
        busy_cnt = 0;
        rise_cnt = 0;
        rx_log.delete();
        mosi_log.delete();
    endtask

    initial begin
        // Reset state
        tick(3);
        chk("rst_cs_n", 32'(cs_n), 32'd1);
        chk("rst_sclk", 32'(sclk), 32'd0);
        chk("rst_mosi", 32'(mosi), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_rx_valid", 32'(rx_valid), 32'd0);
        chk("rst_rd_en", 32'(fifo_rd_en), 32'd0);
        chk("rst_rx_data", rx_data, 32'h0);
        rst = 1'b1;
        tick(2);

        // Single frame
        clear_counts();
        slv_word = 32'h1234_5678;
        push(32'hA5A5_0F0F);
        enable = 1'b1;
        wait_rx(1, 400);
        tick(2);
        chk("single_rx_cnt", 32'(rx_cnt), 32'd1);
        chk("single_rx_data", rx_last, 32'h1234_5678);
        chk("single_rd_cnt", 32'(rd_cnt), 32'd1);
        chk("single_rises", 32'(rise_cnt), 32'd32);
        chk("single_mosi", mosi_cap, 32'hA5A5_0F0F);
        chk("single_cs_low", 32'(low_len), 32'd132);
        tick(10);
        chk("single_idle_busy", 32'(busy), 32'd0);
        chk("single_idle_cs_n", 32'(cs_n), 32'd1);
        chk("single_one_pulse", 32'(rx_cnt), 32'd1);

        // Back-to-back frames
        clear_counts();
        slv_word = 32'hC3C3_0001;
        push(32'h0000_0001);
        push(32'hFFFF_FFFF);
        wait_rx(2, 800);
        tick(2);
        chk("b2b_rx_cnt", 32'(rx_cnt), 32'd2);
        chk("b2b_rd_cnt", 32'(rd_cnt), 32'd2);
        chk("b2b_frames", 32'(mosi_log.size()), 32'd2);
        if (mosi_log.size() == 2) begin
            chk("b2b_mosi0", mosi_log[0], 32'h0000_0001);
            chk("b2b_mosi1", mosi_log[1], 32'hFFFF_FFFF);
        end
        if (rx_log.size() == 2) begin
            chk("b2b_rx0", rx_log[0], 32'hC3C3_0001);
            chk("b2b_rx1", rx_log[1], 32'hC3C3_0001);
        end
        chk("b2b_gap_ge3", 32'(gap_len >= 3), 32'd1);

        // Empty FIFO with enable high
        tick(5);
        clear_counts();
        tick(50);
        chk("empty_rd_cnt", 32'(rd_cnt), 32'd0);
        chk("empty_busy_cnt", 32'(busy_cnt), 32'd0);
        chk("empty_cs_n", 32'(cs_n), 32'd1);

        // Enable dropped after 10 bits
        clear_counts();
        slv_word = 32'h0F0F_F0F0;
        push(32'h3C3C_5A5A);
        wait_rise(10, 200);
        chk("drop_reached_bit10", 32'(rise_cnt), 32'd10);
        enable = 1'b0;
        push(32'h5555_AAAA);
        wait_rx(1, 400);
        tick(2);
        chk("drop_rx_cnt", 32'(rx_cnt), 32'd1);
        chk("drop_rises", 32'(rise_cnt), 32'd32);
        chk("drop_mosi", mosi_cap, 32'h3C3C_5A5A);
        chk("drop_rx_data", rx_last, 32'h0F0F_F0F0);
        tick(50);
        chk("drop_no_fetch", 32'(rd_cnt), 32'd1);
        chk("drop_idle_busy", 32'(busy), 32'd0);

        // Asynchronous reset at bit 16
        clear_counts();
        enable = 1'b1;
        wait_rise(16, 200);
        chk("rst16_reached", 32'(rise_cnt), 32'd16);
        #2;
        rst = 1'b0;
        #1;
        chk("rst16_cs_n", 32'(cs_n), 32'd1);
        chk("rst16_sclk", 32'(sclk), 32'd0);
        chk("rst16_mosi", 32'(mosi), 32'd0);
        chk("rst16_busy", 32'(busy), 32'd0);
        chk("rst16_rd_en", 32'(fifo_rd_en), 32'd0);
        tick(3);
        chk("rst16_rx_valid", 32'(rx_cnt), 32'd0);
        chk("rst16_rx_data", rx_data, 32'h0);
        clear_counts();
        slv_word = 32'hDEAD_BEEF;
        push(32'h9696_6969);
        rst = 1'b1;
        wait_rx(1, 400);
        tick(2);
        chk("post_rst_rx_cnt", 32'(rx_cnt), 32'd1);
        chk("post_rst_rises", 32'(rise_cnt), 32'd32);
        chk("post_rst_mosi", mosi_cap, 32'h9696_6969);
        chk("post_rst_rx_data", rx_last, 32'hDEAD_BEEF);
        chk("post_rst_cs_low", 32'(low_len), 32'd132);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
